// File: rtl/io_conv_pkg.sv
// Shared definitions for the multi-channel I/O conversion poller:
// FSM state encoding, per-channel register offsets and the invalid-code marker.
package io_conv_pkg;

   typedef enum logic [3:0] {
      S_SADDR,
      S_SRD,
      S_SCHK,
      S_DADDR,
      S_DRD,
      S_DCAP,
      S_WADDR,
      S_WR,
      S_WEND
   } state_t;

   localparam logic [15:0] STAT   = 16'd0;
   localparam logic [15:0] DATA   = 16'd1;
   localparam logic [15:0] OUT    = 16'd3;
   localparam logic [15:0] STRIDE = 16'd4;

   localparam logic [7:0] INVALID_CODE = 8'h80;

endpackage

// File: rtl/conv_radix.sv
// Combinational sign-magnitude (two radix-RADIX digits) to 8-bit two's complement
// converter; out-of-range digits yield INVALID_CODE and raise invalid.
module conv_radix
   import io_conv_pkg::*;
#(
   parameter int RADIX = 6
) (
   input  logic [7:0] code,
   output logic [7:0] value,
   output logic       invalid
);

   localparam logic [5:0] RAD6 = 6'(RADIX);

   logic [2:0]        c1;
   logic [2:0]        c0;
   logic [5:0]        mag;
   logic signed [7:0] mag_s;
   logic signed [7:0] res_s;
   logic              unused_msb;

   assign c1         = code[5:3];
   assign c0         = code[2:0];
   assign unused_msb = code[7];

   assign invalid = (int'(c1) >= RADIX) || (int'(c0) >= RADIX);

   // Magnitude never exceeds 63 for legal digits, so 6 bits suffice.
   assign mag   = 6'(c1) * RAD6 + 6'(c0);
   assign mag_s = signed'({2'b00, mag});
   assign res_s = code[6] ? -mag_s : mag_s;

   assign value = invalid ? INVALID_CODE : res_s;

endmodule

// File: rtl/io_conv_poller.sv
// Round-robin bus master: polls NCH status registers, converts a ready channel's
// code and writes the result to that channel's output register.
module io_conv_poller
   import io_conv_pkg::*;
#(
   parameter int          NCH   = 2,
   parameter logic [15:0] BASE  = 16'hAAA0,
   parameter int          RADIX = 6,
   parameter int          FI    = 0,
   localparam int         CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic          clock,
   input  logic          reset_,
   output logic          ior_,
   output logic          iow_,
   output logic [15:0]   addr,
   inout  wire  [7:0]    data,
   output logic [CW-1:0] chan,
   output logic          err
);

   state_t        state, state_nxt;
   logic [CW-1:0] k, k_nxt, k_adv;
   logic [15:0]   addr_nxt, chan_base;
   logic          ior_nxt, iow_nxt, dir, dir_nxt, err_nxt;
   logic [7:0]    out_value, out_nxt, conv_value;
   logic          conv_invalid;

   conv_radix #(.RADIX(RADIX)) u_conv (
      .code    (data),
      .value   (conv_value),
      .invalid (conv_invalid)
   );

   assign data      = dir ? out_value : 8'hzz;
   assign chan      = k;
   assign k_adv     = (k == CW'(NCH - 1)) ? '0 : k + CW'(1);
   assign chan_base = BASE + 16'(k) * STRIDE;

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      ior_nxt   = ior_;
      iow_nxt   = iow_;
      dir_nxt   = dir;
      k_nxt     = k;
      err_nxt   = 1'b0;
      out_nxt   = out_value;
      case (state)
         S_SADDR: begin
            addr_nxt  = chan_base + STAT;
            dir_nxt   = 1'b0;
            state_nxt = S_SRD;
         end
         S_SRD: begin
            ior_nxt   = 1'b0;
            state_nxt = S_SCHK;
         end
         S_SCHK: begin
            ior_nxt = 1'b1;
            if (data[FI]) begin
               state_nxt = S_DADDR;
            end else begin
               k_nxt     = k_adv;
               state_nxt = S_SADDR;
            end
         end
         S_DADDR: begin
            addr_nxt  = chan_base + DATA;
            state_nxt = S_DRD;
         end
         S_DRD: begin
            ior_nxt   = 1'b0;
            state_nxt = S_DCAP;
         end
         S_DCAP: begin
            out_nxt   = conv_value;
            ior_nxt   = 1'b1;
            err_nxt   = conv_invalid;
            state_nxt = S_WADDR;
         end
         S_WADDR: begin
            addr_nxt  = chan_base + OUT;
            dir_nxt   = 1'b1;
            state_nxt = S_WR;
         end
         S_WR: begin
            iow_nxt   = 1'b0;
            state_nxt = S_WEND;
         end
         S_WEND: begin
            iow_nxt   = 1'b1;
            k_nxt     = k_adv;
            state_nxt = S_SADDR;
         end
         default: state_nxt = S_SADDR;
      endcase
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state <= S_SADDR;
         addr  <= 16'h0000;
         ior_  <= 1'b1;
         iow_  <= 1'b1;
         dir   <= 1'b0;
         k     <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         addr  <= addr_nxt;
         ior_  <= ior_nxt;
         iow_  <= iow_nxt;
         dir   <= dir_nxt;
         k     <= k_nxt;
         err   <= err_nxt;
      end
   end

   // Write-data holding register; only meaningful once DIR is set.
   always_ff @(posedge clock) begin
      out_value <= out_nxt;
   end

endmodule

// File: tb/tb_io_conv_poller.sv
// Bench for io_conv_poller: bus-slave model plus a timeline model of the expected
// bus traffic, checked cycle by cycle; a RADIX=8 converter is checked standalone.
module tb_io_conv_poller;

   localparam int          NCH   = 3;
   localparam int          RADIX = 6;
   localparam int          FI    = 1;
   localparam logic [15:0] BASE  = 16'hAAA0;
   localparam int          MAXC  = 128;

   logic        clock = 1'b0;
   logic        reset_;
   logic        ior_, iow_, err;
   logic [15:0] addr;
   logic [1:0]  chan;
   wire  [7:0]  data;

   io_conv_poller #(.NCH(NCH), .BASE(BASE), .RADIX(RADIX), .FI(FI)) u_dut (
      .clock  (clock),
      .reset_ (reset_),
      .ior_   (ior_),
      .iow_   (iow_),
      .addr   (addr),
      .data   (data),
      .chan   (chan),
      .err    (err)
   );

   logic [7:0] c8_code, c8_val;
   logic       c8_inv;

   conv_radix #(.RADIX(8)) u_conv8 (
      .code    (c8_code),
      .value   (c8_val),
      .invalid (c8_inv)
   );

   always #5 clock = ~clock;

   // Slave register file: status (ready at bit FI, noise elsewhere) and data code.
   logic [7:0]     code  [NCH];
   logic [7:0]     noise [NCH];
   logic [NCH-1:0] ready;
   logic [7:0]     rd_val;

   always_comb begin
      rd_val = 8'h00;
      for (int i = 0; i < NCH; i++) begin
         if (addr == BASE + 16'(4 * i)) begin
            rd_val     = noise[i];
            rd_val[FI] = ready[i];
         end
         if (addr == BASE + 16'(4 * i + 1)) rd_val = code[i];
      end
   end

   assign data = (!ior_) ? rd_val : 8'hzz;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit ref_invalid(int c, int radix);
      return (((c >> 3) & 7) >= radix) || ((c & 7) >= radix);
   endfunction

   function automatic int ref_conv(int c, int radix);
      int m;
      if (ref_invalid(c, radix)) return 'h80;
      m = ((c >> 3) & 7) * radix + (c & 7);
      return ((c >> 6) & 1) ? ((256 - m) & 255) : m;
   endfunction

   // Expected bus timeline, indexed by cycle after reset release.
   int exp_addr [MAXC];
   int exp_chan [MAXC];
   int exp_wdat [MAXC];
   bit exp_ior  [MAXC];
   bit exp_iow  [MAXC];
   bit exp_err  [MAXC];
   bit exp_dir  [MAXC];

   task automatic build_model(input int ncyc);
      int s, k, from, upd, sa;
      for (int c = 0; c < MAXC; c++) begin
         exp_addr[c] = 0; exp_chan[c] = 0; exp_wdat[c] = 0;
         exp_ior[c]  = 1; exp_iow[c]  = 1; exp_err[c]  = 0; exp_dir[c] = 0;
      end
      s = 0; k = 0; from = 0;
      while (s < ncyc) begin
         sa = int'(BASE) + 4 * k;
         for (int c = s; c < s + 3; c++) exp_addr[c] = sa;
         exp_ior[s + 1] = 0;
         if (ready[k]) begin
            for (int c = s + 3; c < s + 6; c++) exp_addr[c] = sa + 1;
            for (int c = s + 6; c < s + 9; c++) begin
               exp_addr[c] = sa + 3;
               exp_dir[c]  = 1;
            end
            exp_ior[s + 4]  = 0;
            exp_err[s + 5]  = ref_invalid(int'(code[k]), RADIX);
            exp_iow[s + 7]  = 0;
            exp_wdat[s + 7] = ref_conv(int'(code[k]), RADIX);
            upd = s + 8;
            s   = s + 9;
         end else begin
            upd = s + 2;
            s   = s + 3;
         end
         for (int c = from; c < upd; c++) exp_chan[c] = k;
         from = upd;
         k    = (k + 1) % NCH;
      end
      for (int c = from; c < MAXC; c++) exp_chan[c] = k;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ior"},  ior_,        1);
      check({tag, "_iow"},  iow_,        1);
      check({tag, "_addr"}, addr,        0);
      check({tag, "_chan"}, chan,        0);
      check({tag, "_err"},  err,         0);
      check({tag, "_dir"},  u_dut.dir,   0);
   endtask

   task automatic apply_reset();
      reset_ = 1'b0;
      repeat (2) @(negedge clock);
      check_reset("rst");
   endtask

   // Entered with reset_ low; releases it and checks every cycle against the model.
   task automatic run_scen(input int ncyc, input bit abort_on_write);
      bit aborted = 0;
      build_model(ncyc);
      @(negedge clock);
      reset_ = 1'b1;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clock);
         check("ior_", ior_,      exp_ior[c]);
         check("iow_", iow_,      exp_iow[c]);
         check("addr", addr,      exp_addr[c]);
         check("chan", chan,      exp_chan[c]);
         check("err",  err,       exp_err[c]);
         check("dir",  u_dut.dir, exp_dir[c]);
         if (!exp_iow[c]) check("wdata", data, exp_wdat[c]);
         if (abort_on_write && !exp_iow[c]) begin
            #1 reset_ = 1'b0;
            #1 check_reset("abort");
            aborted = 1;
            break;
         end
      end
      if (abort_on_write) check("abort_reached", aborted, 1);
      if (!aborted) apply_reset();
   endtask

   task automatic set_chan(input int i, input bit rdy, input logic [7:0] c);
      ready[i] = rdy;
      code[i]  = c;
      noise[i] = 8'($urandom);
   endtask

   initial begin
      reset_ = 1'b0;
      ready  = '0;
      for (int i = 0; i < NCH; i++) set_chan(i, 0, 8'h00);
      c8_code = 8'h00;
      repeat (3) @(negedge clock);
      check_reset("init");

      set_chan(0, 0, 8'($urandom)); set_chan(1, 1, 8'h2B); set_chan(2, 0, 8'($urandom));
      run_scen(40, 0);

      set_chan(0, 1, 8'h2B); set_chan(1, 1, 8'h6B); set_chan(2, 1, 8'h33);
      run_scen(60, 0);

      set_chan(0, 1, 8'h40); set_chan(1, 1, 8'h00); set_chan(2, 1, 8'h7F);
      run_scen(45, 0);

      for (int i = 0; i < NCH; i++) set_chan(i, 0, 8'($urandom));
      run_scen(30, 0);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < NCH; i++) set_chan(i, 1'($urandom), 8'($urandom));
         run_scen(30 + int'($urandom_range(0, 60)), 0);
      end

      for (int i = 0; i < NCH; i++) set_chan(i, 1, 8'($urandom));
      run_scen(20, 1);
      for (int i = 0; i < NCH; i++) set_chan(i, 1'($urandom), 8'($urandom));
      run_scen(40, 0);

      c8_code = 8'h3F; #1;
      check("r8_3F", c8_val, 8'h3F);
      c8_code = 8'h7F; #1;
      check("r8_7F", c8_val, 8'hC1);
      for (int r = 0; r < 16; r++) begin
         c8_code = 8'($urandom); #1;
         check("r8_val", c8_val, ref_conv(int'(c8_code), 8));
         check("r8_inv", c8_inv, ref_invalid(int'(c8_code), 8));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/io_conv_poller.md
# io_conv_poller

Multi-channel, parametrised successor of the single-channel polling converter. Sits on the 16-bit-address / 8-bit-data I/O bus as a bus master. Polls NCH input interfaces round-robin, reads a ready channel's 2-digit sign-magnitude code, converts it to 8-bit two's complement, and writes the result to that channel's output port. Differences from the single-channel version:
- Configurable radix.
- Non-blocking polling: it skips a channel that is not ready instead of busy-waiting on it.
- Invalid digits are detected and signalled.

## Interface
Parameters:
- NCH, 2: number of channels, 1..16.
- BASE, 16'hAAA0: address of channel 0 status register. Must be a multiple of 4.
- RADIX, 6: digit radix, 2..8.
- FI, 0: bit of the status register that flags "input ready".

Ports:
- clock  in  1  system clock. All state changes happen on its rising edge.
- reset_  in  1  asynchronous, active-low reset.
- ior_  out  1  I/O read strobe, active low.
- iow_  out  1  I/O write strobe, active low.
- addr  out  16  I/O address.
- data  inout  8  bidirectional data bus. The block drives it only while its internal DIR register is 1; otherwise the bus is high-Z.
- chan  out  $clog2(NCH) (min 1)  index of the channel currently being serviced.
- err  out  1  one-cycle pulse when an invalid code is converted.

## Operation
Address map for channel k:
- status register: BASE+4k
- data register: BASE+4k+1
- output register: BASE+4k+3

Input code layout:
- bit6: sign.
- bits5:3: digit c1.
- bits2:0: digit c0.
- bit7: ignored.

Conversion:
- Magnitude m = c1·RADIX + c0, 6 bits. The maximum value is 63.
- Result = sign ? −m : m, as 8-bit two's complement.
- Negative zero (sign=1, m=0) converts to 8'h00.
- If c1 ≥ RADIX or c0 ≥ RADIX, the result is 8'h80 and err pulses in the capture cycle.

FSM states and transitions. A channel pointer k starts at 0.
- S_SADDR: addr←status(k); DIR←0 → S_SRD
- S_SRD: ior_←0 → S_SCHK
- S_SCHK: sample data[FI]; ior_←1.
  - If the bit is 1 → S_DADDR.
  - Otherwise k←next(k) → S_SADDR.
- S_DADDR: addr←data(k) → S_DRD
- S_DRD: ior_←0 → S_DCAP
- S_DCAP: OUTVALUE←conv(data); ior_←1; err←invalid → S_WADDR
- S_WADDR: addr←out(k); DIR←1 → S_WR
- S_WR: iow_←0 → S_WEND
- S_WEND: iow_←1; k←next(k) → S_SADDR

Pointer advance: next(k) = (k==NCH−1) ? 0 : k+1. This gives strict round-robin. A serviced channel is not revisited until every other channel has been polled once.

## Timing
- Reset values, applied asynchronously while reset_=0:
  - ior_=1, iow_=1, addr=16'h0000
  - DIR=0, so data is Z
  - k=0, chan=0, err=0
  - state S_SADDR
- After reset_ rises, the first rising edge performs S_SADDR.
- Strobe timing:
  - addr is stable for ≥1 full cycle before any strobe falls.
  - addr stays stable while the strobe is low.
  - Every strobe is low for exactly 1 cycle.
- Data sampling: data is sampled on the edge where ior_ returns high.
- Write data hold: data stays driven for one cycle after iow_ rises and is released in the next S_SADDR.
- Cycle counts:
  - Not-ready poll: 3 cycles.
  - Full service, including its status poll: 9 cycles.
  - With all NCH channels idle, a full scan takes 3·NCH cycles.
- chan equals k at all times and updates at the S_SCHK (skip) or S_WEND edge.
- reset_ asserted mid-transaction aborts immediately: strobes go to 1 and data goes to Z. No partial write is repeated, and service resumes at channel 0.

## Structure
- Package io_conv_pkg holds:
  - state enum/localparams
  - register offsets (STAT=0, DATA=1, OUT=3, STRIDE=4)
  - the invalid-code constant 8'h80
- Sub-module conv_radix, purely combinational:
  - Parameter RADIX.
  - Inputs code[7:0]; outputs value[7:0] and invalid.
  - Implemented as c1·RADIX+c0, then conditional two's-complement negate.
- The top FSM instantiates one conv_radix connected to data.

## Test plan
- RADIX=6, NCH=1, status FI=1, data 8'h2B (c1=5, c0=3) → write of 8'h21 to AAA3. Then data 8'h6B → write of 8'hDF.
- RADIX=6, data 8'h33 (c1=6) → write of 8'h80 and err high for 1 cycle. Data 8'h40 → write of 8'h00 with err=0.
- RADIX=8, data 8'h3F → 8'h3F; data 8'h7F → 8'hC1 (−63).
- NCH=3, only channel 1 ready:
  - Bus sequence: read AAA0, read AAA4 (FI=1), read AAA5, write AAA7, then read AAA8.
  - No write occurs to AAA3 or AAAB.
- All channels ready: writes go to channels 0, 1, 2, 0, … in order, each 9 cycles apart.
- Assert reset_ during S_WR:
  - iow_ goes to 1 and data goes to Z within the same cycle.
  - After release, the first access is a read of AAA0.
  - Check strobe low width = 1 cycle and addr setup ≥ 1 cycle throughout the test.
